// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and constants for the quadrature generator.
package quad_encoder_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPh1,
        StPh2,
        StPh3,
        StPh4,
        StFinish
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // (a,b) codes; up has A leading B, down has B leading A
    localparam logic [1:0] UP_PH1 = 2'b10;
    localparam logic [1:0] UP_PH2 = 2'b11;
    localparam logic [1:0] UP_PH3 = 2'b01;
    localparam logic [1:0] UP_PH4 = 2'b00;

    localparam logic [1:0] DN_PH1 = 2'b01;
    localparam logic [1:0] DN_PH2 = 2'b11;
    localparam logic [1:0] DN_PH3 = 2'b10;
    localparam logic [1:0] DN_PH4 = 2'b00;

    localparam logic [1:0] AB_IDLE = 2'b00;

    // Output code for a state; IDLE and FINISH rest at 00
    function automatic logic [1:0] phase_code(input state_e st, input logic dir);
        logic [1:0] code;
        code = AB_IDLE;
        case (st)
            StPh1:   code = (dir == DIR_UP) ? UP_PH1 : DN_PH1;
            StPh2:   code = (dir == DIR_UP) ? UP_PH2 : DN_PH2;
            StPh3:   code = (dir == DIR_UP) ? UP_PH3 : DN_PH3;
            StPh4:   code = (dir == DIR_UP) ? UP_PH4 : DN_PH4;
            default: code = AB_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_phase_timer.sv
// Dwell timer: one-cycle expire pulse DWELL cycles after a load.
module quad_encoder_gen_phase_timer #(
    parameter int unsigned DWELL = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;

    assign expire = active_q && (cnt_q == '0);

    // Reload on load, otherwise count down and go inactive after expiring
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = CntW'(DWELL - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: one full quadrature cycle per commanded step.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int unsigned DWELL = 8192,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rot_a,
    output logic             rot_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [1:0]       rot_q, rot_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             load;
    logic             expire;

    quad_encoder_gen_phase_timer #(
        .DWELL(DWELL)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .expire(expire)
    );

    // Next-state: FSM, step bookkeeping, and outputs derived from the next state
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_count;
                    if (cmd_count == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StPh1;
                        load    = 1'b1;
                    end
                end
            end
            StPh1: begin
                if (expire) begin
                    state_d = StPh2;
                    load    = 1'b1;
                end
            end
            StPh2: begin
                if (expire) begin
                    state_d = StPh3;
                    load    = 1'b1;
                end
            end
            StPh3: begin
                if (expire) begin
                    state_d = StPh4;
                    load    = 1'b1;
                end
            end
            StPh4: begin
                if (expire) begin
                    pos_d = (dir_q == DIR_UP) ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StPh1;
                        load    = 1'b1;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Registered outputs follow the state being entered, so they line up with it
        rot_d   = phase_code(state_d, dir_d);
        done_d  = (state_d == StFinish);
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= DIR_DOWN;
            rem_q   <= '0;
            pos_q   <= '0;
            rot_q   <= AB_IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign rot_a     = rot_q[1];
    assign rot_b     = rot_q[0];
    assign done      = done_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen with a behavioural quadrature-decoder model.
module tb_quad_encoder_gen;

    localparam int unsigned DWELL = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_ready;
    logic             rot_a, rot_b, busy, done;
    logic [CNT_W-1:0] pos;

    always #5 clk = ~clk;

    quad_encoder_gen #(
        .DWELL(DWELL),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_count(cmd_count),
        .rot_a    (rot_a),
        .rot_b    (rot_b),
        .busy     (busy),
        .done     (done),
        .pos      (pos)
    );

    typedef struct {
        bit         is_done;
        logic [1:0] ab;
        int         cyc;
        logic [7:0] pos;
    } ev_t;

    ev_t        q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] pos_m = 8'h00;
    logic [7:0] dec = 8'h00;
    logic [1:0] prev_ab = 2'b00;
    int         ready_chk = -1;

    // Edge counter used as the time base for expected events
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Expected (a,b) per phase: up 10,11,01,00; down 01,11,10,00
    function automatic logic [1:0] exp_code(input logic dir, input int ph);
        logic [1:0] c;
        case (ph)
            0:       c = dir ? 2'b10 : 2'b01;
            1:       c = 2'b11;
            2:       c = dir ? 2'b01 : 2'b10;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Queue every expected phase change and the done pulse for a command accepted at edge t
    task automatic push_cmd(input logic dir, input int n, input int t);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 4; p++) begin
                e.is_done = 1'b0;
                e.ab      = exp_code(dir, p);
                e.cyc     = t + 4 * DWELL * i + DWELL * p;
                e.pos     = 8'h00;
                q.push_back(e);
            end
            pos_m = dir ? pos_m + 8'd1 : pos_m - 8'd1;
        end
        e.is_done = 1'b1;
        e.ab      = 2'b00;
        e.cyc     = t + 4 * DWELL * n;
        e.pos     = pos_m;
        q.push_back(e);
    endtask

    // Called at a negedge: wait for ready, present the command, accept on the next edge
    task automatic issue(input logic dir, input int n, input bit hold);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_dir   = dir;
        cmd_count = 8'(n);
        cmd_valid = 1'b1;
        push_cmd(dir, n, cyc + 1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Wait for all expected events and ready; optionally scribble on the command inputs
    task automatic wait_idle(input bit hold);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0 && cmd_ready) break;
            if (hold) begin
                cmd_dir   = guard[0];
                cmd_count = 8'(guard * 7 + 5);
            end
            guard++;
            if (guard > 6000) begin
                check("wait_idle_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    // Monitor: pop and compare on each rot change and each done pulse
    always @(negedge clk) begin
        logic [1:0] cur;
        ev_t        e;
        cur = {rot_a, rot_b};
        if (reset) begin
            prev_ab   = cur;
            dec       = 8'h00;
            ready_chk = -1;
        end else begin
            if (ready_chk == cyc) begin
                check("ready_after_done", {61'd0, cmd_ready, busy, done}, 64'b100);
                ready_chk = -1;
            end
            if (cur != prev_ab) begin
                check("one_bit_change", $countones(cur ^ prev_ab), 64'd1);
                if (prev_ab == 2'b01 && cur == 2'b00) dec = dec + 8'd1;
                if (prev_ab == 2'b10 && cur == 2'b00) dec = dec - 8'd1;
                if (q.size() == 0 || q[0].is_done) begin
                    check("unexpected_rot_edge", {62'd0, cur}, {62'd0, prev_ab});
                end else begin
                    e = q.pop_front();
                    check("rot_ab", {62'd0, cur}, {62'd0, e.ab});
                    check("rot_time", cyc, e.cyc);
                    check("busy_in_phase", {63'd0, busy}, 64'd1);
                end
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("done_time", cyc, e.cyc);
                    check("done_pos", pos, e.pos);
                    check("decoder_count", dec, e.pos);
                    check("ready_low_at_done", {63'd0, cmd_ready}, 64'd0);
                    ready_chk = cyc + 1;
                end
            end
            prev_ab = cur;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {rot_a, rot_b, cmd_ready, busy, done, pos}, {2'b00, 3'b100, 8'h00});
        #2 reset = 1'b0;

        // Idle with no command
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                check("idle", {rot_a, rot_b, cmd_ready, busy, done, pos},
                      {2'b00, 3'b100, 8'h00});
            end
        end

        // Up 3 steps -> pos 3
        issue(1'b1, 3, 1'b0);
        wait_idle(1'b0);
        check("pos_up3", pos, 64'd3);

        // Back to 0, then down 2 -> 254
        issue(1'b0, 3, 1'b0);
        wait_idle(1'b0);
        issue(1'b0, 2, 1'b0);
        wait_idle(1'b0);
        check("pos_down2", pos, 64'd254);
        check("dec_down2", dec, 64'd254);

        // Zero-step command: only a done pulse
        issue(1'b1, 0, 1'b0);
        wait_idle(1'b0);
        check("pos_zero_cmd", pos, 64'd254);

        // cmd_valid held high with changing inputs; latched command only
        issue(1'b1, 2, 1'b1);
        wait_idle(1'b1);
        check("pos_wrap_up", pos, 64'd0);
        issue(1'b0, 1, 1'b0);
        wait_idle(1'b0);
        check("pos_wrap_down", pos, 64'd255);

        // Reset in the middle of PH2
        issue(1'b1, 1, 1'b0);
        repeat (DWELL + 1) @(negedge clk);
        check("in_ph2", {62'd0, rot_a, rot_b}, 64'b11);
        #2 reset = 1'b1;
        #1;
        check("mid_reset", {rot_a, rot_b, cmd_ready, busy, done, pos}, {2'b00, 3'b100, 8'h00});
        q.delete();
        pos_m = 8'h00;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (10) @(negedge clk);
        issue(1'b1, 1, 1'b0);
        wait_idle(1'b0);
        check("pos_after_reset", pos, 64'd1);

        // Full-width count: 255 steps, 1 + 255 wraps to 0
        issue(1'b1, 255, 1'b0);
        wait_idle(1'b0);
        check("pos_255_steps", pos, 64'd0);
        check("queue_drained", q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
